reg_file_rename: RTL

//   Architectural register file plus rename-status table; the consumer of the ROB commit stream.

---
 rtl/reg_file_rename_if.sv | 45 ++++
 rtl/reg_file_rename.sv | 100 ++++++++++
 2 files changed

// File: rtl/reg_file_rename_if.sv
// Issue/commit/read bundle between the rename-aware register file and its users.
// master = issue/commit side driving requests, slave = register file.
interface reg_file_rename_if #(
   parameter int ROB_SIZE_LOG = 4,
   parameter int XLEN         = 32
);
   logic                    rdy;
   logic                    jump_rst;
   logic                    commit_send;
   logic [4:0]              commit_reg;
   logic [XLEN-1:0]         commit_value;
   logic [ROB_SIZE_LOG-1:0] commit_reorder;
   logic                    issue_valid;
   logic [4:0]              issue_rd;
   logic [ROB_SIZE_LOG-1:0] issue_reorder;
   logic [4:0]              rs1_idx;
   logic [4:0]              rs2_idx;
   logic [XLEN-1:0]         rs1_val;
   logic                    rs1_busy;
   logic [ROB_SIZE_LOG-1:0] rs1_tag;
   logic [XLEN-1:0]         rs2_val;
   logic                    rs2_busy;
   logic [ROB_SIZE_LOG-1:0] rs2_tag;
   logic [31:0]             retired_cnt;

   modport master (
      output rdy, jump_rst,
      output commit_send, commit_reg, commit_value, commit_reorder,
      output issue_valid, issue_rd, issue_reorder,
      output rs1_idx, rs2_idx,
      input  rs1_val, rs1_busy, rs1_tag,
      input  rs2_val, rs2_busy, rs2_tag,
      input  retired_cnt
   );

   modport slave (
      input  rdy, jump_rst,
      input  commit_send, commit_reg, commit_value, commit_reorder,
      input  issue_valid, issue_rd, issue_reorder,
      input  rs1_idx, rs2_idx,
      output rs1_val, rs1_busy, rs1_tag,
      output rs2_val, rs2_busy, rs2_tag,
      output retired_cnt
   );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename (busy/tag) status, fed by ROB commits.
// Reads are combinational with same-cycle commit bypass; rdy low freezes all state, no backpressure.
module reg_file_rename #(
   parameter int ROB_SIZE_LOG = 4,
   parameter int XLEN         = 32
) (
   input logic              clk,
   input logic              rst,
   reg_file_rename_if.slave bus
);
   typedef struct packed {
      logic [XLEN-1:0]         val;
      logic                    busy;
      logic [ROB_SIZE_LOG-1:0] tag;
   } read_t;

   logic [XLEN-1:0]         regs [32];
   logic [ROB_SIZE_LOG-1:0] tag  [32];
   logic [31:0]             busy;
   logic [31:0]             retired_cnt;

   logic                    commit_send;
   logic [4:0]              commit_reg;
   logic [XLEN-1:0]         commit_value;
   logic [ROB_SIZE_LOG-1:0] commit_reorder;
   logic                    issue_en;
   logic                    commit_wr;
   logic                    commit_clr;
   read_t                   rs1_rd;
   read_t                   rs2_rd;

   assign commit_send    = bus.commit_send;
   assign commit_reg     = bus.commit_reg;
   assign commit_value   = bus.commit_value;
   assign commit_reorder = bus.commit_reorder;

   // A flush cancels any rename issued in the same cycle.
   assign issue_en   = bus.issue_valid && !bus.jump_rst && (bus.issue_rd != 5'd0);
   assign commit_wr  = commit_send && (commit_reg != 5'd0);
   assign commit_clr = commit_wr && (tag[commit_reg] == commit_reorder)
                       && !(issue_en && (bus.issue_rd == commit_reg));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
            tag[i]  <= '0;
         end
         busy        <= '0;
         retired_cnt <= '0;
      end else if (bus.rdy) begin
         if (commit_send) begin
            retired_cnt <= retired_cnt + 32'd1;
         end
         if (commit_wr) begin
            regs[commit_reg] <= commit_value;
         end
         if (commit_clr) begin
            busy[commit_reg] <= 1'b0;
         end
         if (issue_en) begin
            busy[bus.issue_rd] <= 1'b1;
            tag[bus.issue_rd]  <= bus.issue_reorder;
         end
         if (bus.jump_rst) begin
            busy <= '0;
         end
      end
   end

   // Tag equality alone identifies the producer; ROB indices carry no age.
   function automatic read_t read_port(input logic [4:0] idx);
      read_t r;
      r = '0;
      if (idx != 5'd0) begin
         r.tag = tag[idx];
         if (busy[idx] && commit_send && (commit_reg == idx) && (tag[idx] == commit_reorder)) begin
            r.val  = commit_value;
            r.busy = 1'b0;
         end else begin
            r.val  = regs[idx];
            r.busy = busy[idx];
         end
      end
      return r;
   endfunction

   always_comb begin
      rs1_rd = read_port(bus.rs1_idx);
      rs2_rd = read_port(bus.rs2_idx);
   end

   assign bus.rs1_val     = rs1_rd.val;
   assign bus.rs1_busy    = rs1_rd.busy;
   assign bus.rs1_tag     = rs1_rd.tag;
   assign bus.rs2_val     = rs2_rd.val;
   assign bus.rs2_busy    = rs2_rd.busy;
   assign bus.rs2_tag     = rs2_rd.tag;
   assign bus.retired_cnt = retired_cnt;
endmodule
